// File: rtl/cvxif_instr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cvxif_instr_pkg : shared types for the custom-vector coprocessor           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package cvxif_instr_pkg;

  localparam int unsigned c_id_width   = 4;
  localparam int unsigned c_vlen_width = 4;
  localparam int unsigned c_op_width   = 3;

  typedef logic [c_vlen_width-1:0] vlen_t;

  typedef enum logic [c_op_width-1:0] {
    VEC_ADD = 3'd0,
    VEC_SUB = 3'd1,
    VEC_MUL = 3'd2,
    VEC_AND = 3'd3,
    VEC_OR  = 3'd4,
    VEC_XOR = 3'd5,
    VEC_SLL = 3'd6,
    VEC_SRL = 3'd7
  } custom_vec_op_e;

  typedef struct packed {
    logic [c_id_width-1:0] id;
    logic [4:0]            rd;
    logic                  we;
    custom_vec_op_e        op;
    vlen_t                 vlen;
    logic                  committed;
    logic                  killed;
  } copro_queue_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } copro_exec_state_e;

  function automatic logic id_match(input copro_queue_entry_t e,
                                    input logic [c_id_width-1:0] id);
    return e.id == id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/copro_instr_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | copro_instr_queue : in-order instruction buffer with commit/kill by id     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module copro_instr_queue
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned QueueDepth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  copro_queue_entry_t    push_entry_i,
  input  logic                  pop_i,
  input  logic                  commit_valid_i,
  input  logic [c_id_width-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output copro_queue_entry_t    head_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned c_ptr_w = $clog2(QueueDepth);

  copro_queue_entry_t r_mem [QueueDepth];
  logic [QueueDepth-1:0] r_valid;
  logic [c_ptr_w:0]      r_wr_ptr;
  logic [c_ptr_w:0]      r_rd_ptr;
  copro_queue_entry_t    w_push_entry;
  logic [c_ptr_w-1:0]    w_wr_idx;
  logic [c_ptr_w-1:0]    w_rd_idx;

  assign w_wr_idx = r_wr_ptr[c_ptr_w-1:0];
  assign w_rd_idx = r_rd_ptr[c_ptr_w-1:0];
  assign empty_o  = (r_wr_ptr == r_rd_ptr);
  assign full_o   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]);
  assign head_o   = r_mem[w_rd_idx];

  // A commit arriving alongside the issue of the same id must not be lost.
  always_comb begin
    w_push_entry = push_entry_i;
    if (commit_valid_i && id_match(push_entry_i, commit_id_i)) begin
      w_push_entry.committed = 1'b1;
      w_push_entry.killed    = commit_kill_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= '0;
      for (int i = 0; i < QueueDepth; i++) r_mem[i] <= '0;
    end else begin
      if (commit_valid_i) begin
        for (int i = 0; i < QueueDepth; i++) begin
          if (r_valid[i] && id_match(r_mem[i], commit_id_i)) begin
            r_mem[i].committed <= 1'b1;
            r_mem[i].killed    <= commit_kill_i;
          end
        end
      end
      if (push_i && !full_o) begin
        r_mem[w_wr_idx]   <= w_push_entry;
        r_valid[w_wr_idx] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (pop_i && !empty_o) begin
        r_valid[w_rd_idx] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/copro_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | copro_exec_ctrl : issue/commit/result sequencer for the vector datapath    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module copro_exec_ctrl
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned VlenWidth  = 4,
  parameter int unsigned OpWidth    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [IdWidth-1:0]   issue_id_i,
  input  logic [4:0]           issue_rd_i,
  input  logic                 dec_accept_i,
  input  logic                 dec_writeback_i,
  input  logic [OpWidth-1:0]   dec_op_i,
  input  logic [VlenWidth-1:0] dec_vlen_i,
  input  logic                 commit_valid_i,
  input  logic [IdWidth-1:0]   commit_id_i,
  input  logic                 commit_kill_i,
  output logic                 exec_valid_o,
  output logic [OpWidth-1:0]   exec_op_o,
  output logic [VlenWidth-1:0] exec_elem_o,
  output logic                 exec_last_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [IdWidth-1:0]   result_id_o,
  output logic [4:0]           result_rd_o,
  output logic                 result_we_o,
  output logic                 busy_o
);

  copro_exec_state_e    r_state;
  copro_queue_entry_t   w_push_entry;
  copro_queue_entry_t   w_head;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;

  logic [IdWidth-1:0]   r_cur_id;
  logic [4:0]           r_cur_rd;
  logic                 r_cur_we;
  logic [OpWidth-1:0]   r_cur_op;
  logic [VlenWidth-1:0] r_cur_vlen;
  logic [VlenWidth-1:0] r_elem;
  logic                 r_exec_valid;
  logic                 r_exec_last;
  logic                 r_result_valid;

  assign issue_ready_o = !w_full;
  assign w_push        = issue_valid_i && !w_full && dec_accept_i;
  // Killed heads are popped too; the FSM just does not load them.
  assign w_pop         = (r_state == ST_IDLE) && !w_empty && w_head.committed;

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.id   = issue_id_i;
    w_push_entry.rd   = issue_rd_i;
    w_push_entry.we   = dec_writeback_i;
    w_push_entry.op   = custom_vec_op_e'(dec_op_i);
    w_push_entry.vlen = dec_vlen_i;
  end

  copro_instr_queue #(
    .QueueDepth(QueueDepth)
  ) u_queue (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .push_i         (w_push),
    .push_entry_i   (w_push_entry),
    .pop_i          (w_pop),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .head_o         (w_head),
    .empty_o        (w_empty),
    .full_o         (w_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_cur_id       <= '0;
      r_cur_rd       <= '0;
      r_cur_we       <= 1'b0;
      r_cur_op       <= '0;
      r_cur_vlen     <= '0;
      r_elem         <= '0;
      r_exec_valid   <= 1'b0;
      r_exec_last    <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop && !w_head.killed) begin
            r_cur_id   <= w_head.id;
            r_cur_rd   <= w_head.rd;
            r_cur_we   <= w_head.we;
            r_cur_op   <= w_head.op;
            r_cur_vlen <= w_head.vlen;
            r_elem     <= '0;
            if (w_head.vlen != '0) begin
              r_state      <= ST_EXEC;
              r_exec_valid <= 1'b1;
              r_exec_last  <= (w_head.vlen == vlen_t'(1));
            end else begin
              r_state        <= ST_RESP;
              r_result_valid <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (r_exec_last) begin
            r_state        <= ST_RESP;
            r_exec_valid   <= 1'b0;
            r_exec_last    <= 1'b0;
            r_elem         <= '0;
            r_result_valid <= 1'b1;
          end else begin
            r_elem      <= r_elem + VlenWidth'(1);
            r_exec_last <= (r_elem + VlenWidth'(1)) == (r_cur_vlen - VlenWidth'(1));
          end
        end
        ST_RESP: begin
          if (result_ready_i) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign exec_valid_o   = r_exec_valid;
  assign exec_op_o      = r_cur_op;
  assign exec_elem_o    = r_elem;
  assign exec_last_o    = r_exec_last;
  assign result_valid_o = r_result_valid;
  assign result_id_o    = r_cur_id;
  assign result_rd_o    = r_cur_rd;
  assign result_we_o    = r_cur_we;
  assign busy_o         = !w_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/copro_exec_ctrl.md
Name: copro_exec_ctrl

Overview:
- Sequencing controller for the CV-X-IF example coprocessor; sits between the core's issue/commit/result interfaces and the custom-vector datapath.
- Takes the instruction decoder's per-request decision (accept, writeback, op, vlen) and queues accepted instructions in order.
- Holds each queued instruction until the core commits or kills it, then sequences committed ones element-by-element through the datapath.
- Returns one result per committed instruction over a valid/ready handshake.

Parameters:
- QueueDepth, 4, number of outstanding accepted instructions; power of two, >=2.
- IdWidth, 4, width of X-IF instruction id.
- VlenWidth, 4, width of vector length field (cvxif_instr_pkg::vlen_t).
- OpWidth, 3, width of cvxif_instr_pkg::custom_vec_op_e.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  core offers an instruction
- issue_ready_o  out  1  controller can take it
- issue_id_i  in  IdWidth  id of offered instruction
- issue_rd_i  in  5  destination register
- dec_accept_i  in  1  decoder accept (combinational, same cycle)
- dec_writeback_i  in  1  decoder writeback flag
- dec_op_i  in  OpWidth  decoded op
- dec_vlen_i  in  VlenWidth  decoded element count
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  IdWidth  committed id
- commit_kill_i  in  1  1 = kill, 0 = commit
- exec_valid_o  out  1  datapath element strobe
- exec_op_o  out  OpWidth  op of executing instruction
- exec_elem_o  out  VlenWidth  element index
- exec_last_o  out  1  final element of instruction
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  IdWidth  result id
- result_rd_o  out  5  result rd
- result_we_o  out  1  writeback flag
- busy_o  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst_ni=0): all outputs 0 except issue_ready_o=1. Queue empty, FSM=IDLE, counters 0. Reset mid-operation discards all entries and any pending result.
- issue_ready_o = !queue_full. It is never gated by dec_accept_i and there is no full-queue bypass.
- Issue fires when issue_valid_i & issue_ready_o:
  - dec_accept_i=1: enqueue {id, rd, we, op, vlen, committed=0, killed=0}.
  - dec_accept_i=0: nothing is stored.
- Commit (commit_valid_i=1):
  - Every valid queue entry whose id matches sets committed=1, plus killed=commit_kill_i.
  - An entry being enqueued in the same cycle with a matching id captures the commit too.
  - An unknown id is ignored.
  - Commits never affect the instruction already in EXEC/RESP, which is committed by construction.
- FSM IDLE:
  - Head committed & !killed: pop the head into the exec register. Go to EXEC if vlen!=0, else RESP.
  - Head killed: pop it, stay in IDLE, emit no result (one cycle per killed entry).
  - Head uncommitted or queue empty: wait.
- FSM EXEC:
  - exec_valid_o=1 every cycle; exec_elem_o counts 0..vlen-1.
  - exec_last_o=1 when elem==vlen-1; the next state is then RESP.
  - There is no stall; the datapath takes one element per cycle.
- FSM RESP:
  - result_valid_o=1 with id/rd/we held stable until result_ready_i.
  - On handshake, go to IDLE; the next pop can happen no earlier than the following cycle.
  - A result is produced even when we=0.
- Latency: commit in cycle N with the queue otherwise idle gives pop at N+1, exec elements N+2..N+1+vlen, and result_valid_o at N+2+vlen (N+2 if vlen=0).
- Pointers: log2(QueueDepth) bits plus one wrap bit. Full when the indices are equal and the wrap bits differ. A push and a pop in the same cycle are both honoured, so the count is unchanged.
- Ordering: results always return in issue order.

Decomposition:
- cvxif_instr_pkg: custom_vec_op_e, vlen_t, and a new copro_queue_entry_t struct {id, rd, we, op, vlen, committed, killed}, plus the FSM state enum copro_exec_state_e.
- Sub-module copro_instr_queue: circular buffer with associative commit/kill id match and push/pop. The FSM stays in the top module.

Test Plan:
- Reset: hold rst_ni=0 mid-EXEC -> all outputs 0, issue_ready_o=1, busy_o=0 asynchronously.
- Single op: issue id=3, vlen=4, we=1, commit id=3 at N -> exec_elem 0,1,2,3 at N+2..N+5 (exec_last at N+5), result_valid at N+6 with id=3. Hold result_ready_i low 3 cycles -> outputs stable.
- Kill: issue ids 1,2 then kill 1, commit 2 -> no result for 1, exec for id 2 starts one cycle after id 1 is dropped, result id=2 only.
- Full queue: issue 4 accepted uncommitted ops -> issue_ready_o=0 on 5th. Commit head -> ready reasserts the cycle after the pop.
- Decoder reject plus zero length: an issue with dec_accept_i=0 enqueues nothing. An accepted op with vlen=0 committed -> no exec_valid_o, result at N+2.
- Same-cycle issue+commit of id=7, vlen=1 -> entry captured committed; result returns normally. Commit of unknown id=9 is ignored with no state change.
